axi_lite_master: RTL and testbench
==================================

// Module: axi_lite_master
// PURPOSE
//  AXI4-Lite initiator (master): turns single-beat commands from a local valid/ready
//  port into AW/W/B or AR/R transactions. Returns BRESP/RRESP and RDATA on a response
//  port. Counterpart of the memory-side AXI4-Lite slave. Drives it from CPU/DMA glue.
//  One transaction in flight at a time; no bursts, no WSTRB (full-word writes only).
// PARAMETERS
//  ADDR_WIDTH  32  width of cmd address and AWADDR/ARADDR
//  DATA_WIDTH  32  width of cmd write data, WDATA, RDATA, rsp read data
// PORTS
//  i_w_aclk        in   1           single clock, all logic on rising edge
//  i_w_areset      in   1           synchronous, active-high reset
//  i_w_cmd_valid   in   1           command request
//  o_w_cmd_ready   out  1           command accepted when valid&ready
//  i_w_cmd_we      in   1           1=write, 0=read
//  i_w_cmd_addr    in   ADDR_WIDTH  byte address
//  i_w_cmd_wdata   in   DATA_WIDTH  write data (ignored for reads)
//  o_w_rsp_valid   out  1           response available
//  i_w_rsp_ready   in   1           response consumed when valid&ready
//  o_w_rsp_we      out  1           echo of cmd_we for this response
//  o_w_rsp_resp    out  2           BRESP or RRESP as received
//  o_w_rsp_rdata   out  DATA_WIDTH  RDATA (0 for writes)
//  o_w_awvalid/i_w_awready/o_w_awaddr[ADDR_WIDTH]    AW channel
//  o_w_wvalid/i_w_wready/o_w_wdata[DATA_WIDTH]       W channel
//  i_w_bvalid/o_w_bready/i_w_bresp[2]                B channel
//  o_w_arvalid/i_w_arready/o_w_araddr[ADDR_WIDTH]    AR channel
//  i_w_rvalid/o_w_rready/i_w_rresp[2]/i_w_rdata[DATA_WIDTH]  R channel
// BEHAVIOUR
//  - Reset (sync, i_w_areset=1 at edge): state=IDLE; all AXI valids, bready, rready,
//    rsp_valid =0; addr/data/resp/rdata regs =0. cmd_ready=1 in the first cycle after.
//  - Reset mid-transaction: abandon it, return to IDLE, drop all valids. No response.
//  - o_w_cmd_ready = (state==IDLE); combinational from state only.
//  - FSM (one-hot): IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
//    IDLE: on cmd handshake latch addr/wdata/we. Go to WR_REQ (we=1) else RD_REQ.
//    WR_REQ: awvalid and wvalid both assert next cycle. Each drops independently
//      on its own handshake (aw_done/w_done flags). When both are done go to WR_RESP.
//      Handshakes may land the same cycle or in either order.
//    WR_RESP: bready=1; on bvalid latch bresp, rdata=0, then go to RSP.
//    RD_REQ: arvalid=1 until arready, then go to RD_DATA.
//    RD_DATA: rready=1; on rvalid latch rresp/rdata, then go to RSP.
//    RSP: rsp_valid=1, held stable until rsp_ready. Then go to IDLE.
//  - AXI rule: once asserted, a valid and its payload stay stable until the handshake.
//    Valids never depend combinationally on the slave's ready.
//  - bready/rready are asserted only in WR_RESP/RD_DATA. B/R beats outside them are
//    not sampled.
//  - Latency, zero-wait slave: cmd hs cycle 0 -> AW/W hs cycle 1 -> B hs cycle 2 ->
//    rsp_valid cycle 3. Read takes the same, with AR/R.
//  - resp is passed through unmodified, including SLVERR/DECERR. It carries no
//    local error codes.
//  - cmd_valid while busy: it is stalled (ready=0), not dropped.
// STRUCTURE
//  - Shared package axi_lite_pkg:
//    RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//    One-hot state localparams for the master FSM.
//  - Single module; no sub-module. aw_done/w_done flags sit inline in the FSM.
// TESTING
//  Bench: behavioural AXI4-Lite slave with per-channel programmable ready/valid delays.
//  1 write 0x0000_0010<=0xDEAD_BEEF, zero wait -> AWADDR=0x10, WDATA=0xDEADBEEF,
//    rsp_valid cycle 3, resp=00, rsp_we=1.
//  2 read 0x10 after test 1 -> ARADDR=0x10, rsp_rdata=0xDEADBEEF, resp=00, rsp_we=0.
//  3 write with wready delayed 3 cycles, awready immediate -> awvalid drops after 1
//    cycle, wvalid held 4 cycles, WDATA stable, one B accepted.
//  4 read with rvalid delay 5 and rsp_ready low 2 cycles after rsp_valid -> rsp held
//    stable, cmd_ready=0 throughout, returns to 1 after rsp handshake.
//  5 slave returns RRESP=2'b10, rdata=0x1234 -> rsp_resp=10, rsp_rdata=0x1234.
//  6 assert i_w_areset during WR_RESP -> next cycle all valids/readies 0,
//    cmd_ready=1, no rsp_valid.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the one-hot state encoding of the
// master FSM.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // One-hot encoding keeps each state decode down to a single flop bit.
   typedef enum logic [5:0] {
      ST_IDLE    = 6'b000001,
      ST_WR_REQ  = 6'b000010,
      ST_WR_RESP = 6'b000100,
      ST_RD_REQ  = 6'b001000,
      ST_RD_DATA = 6'b010000,
      ST_RSP     = 6'b100000
   } masterState_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns one local valid/ready command at a time into an AW/W/B or
// AR/R transaction and hands BRESP/RRESP plus RDATA back on the response port.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_w_aclk,
   input  logic                  i_w_areset,
   input  logic                  i_w_cmd_valid,
   output logic                  o_w_cmd_ready,
   input  logic                  i_w_cmd_we,
   input  logic [ADDR_WIDTH-1:0] i_w_cmd_addr,
   input  logic [DATA_WIDTH-1:0] i_w_cmd_wdata,
   output logic                  o_w_rsp_valid,
   input  logic                  i_w_rsp_ready,
   output logic                  o_w_rsp_we,
   output logic [1:0]            o_w_rsp_resp,
   output logic [DATA_WIDTH-1:0] o_w_rsp_rdata,
   output logic                  o_w_awvalid,
   input  logic                  i_w_awready,
   output logic [ADDR_WIDTH-1:0] o_w_awaddr,
   output logic                  o_w_wvalid,
   input  logic                  i_w_wready,
   output logic [DATA_WIDTH-1:0] o_w_wdata,
   input  logic                  i_w_bvalid,
   output logic                  o_w_bready,
   input  logic [1:0]            i_w_bresp,
   output logic                  o_w_arvalid,
   input  logic                  i_w_arready,
   output logic [ADDR_WIDTH-1:0] o_w_araddr,
   input  logic                  i_w_rvalid,
   output logic                  o_w_rready,
   input  logic [1:0]            i_w_rresp,
   input  logic [DATA_WIDTH-1:0] i_w_rdata
);

   masterState_t r_state;
   masterState_t w_stateNext;

   logic                  r_awDone;
   logic                  r_wDone;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [1:0]            r_resp;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic w_cmdHs;
   logic w_awHs;
   logic w_wHs;
   logic w_bHs;
   logic w_rHs;

   assign o_w_cmd_ready = (r_state == ST_IDLE);

   assign w_cmdHs = i_w_cmd_valid && o_w_cmd_ready;
   assign w_awHs  = o_w_awvalid && i_w_awready;
   assign w_wHs   = o_w_wvalid && i_w_wready;
   assign w_bHs   = i_w_bvalid && o_w_bready;
   assign w_rHs   = i_w_rvalid && o_w_rready;

   assign o_w_awaddr    = r_addr;
   assign o_w_araddr    = r_addr;
   assign o_w_wdata     = r_wdata;
   assign o_w_rsp_we    = r_we;
   assign o_w_rsp_resp  = r_resp;
   assign o_w_rsp_rdata = r_rdata;

   always_ff @(posedge i_w_aclk) begin
      if (i_w_areset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Valids come from registered state and done flags only, so none of them can
   // follow a slave ready combinationally.
   always_comb begin
      w_stateNext   = r_state;
      o_w_awvalid   = 1'b0;
      o_w_wvalid    = 1'b0;
      o_w_bready    = 1'b0;
      o_w_arvalid   = 1'b0;
      o_w_rready    = 1'b0;
      o_w_rsp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_w_cmd_valid) begin
               w_stateNext = i_w_cmd_we ? ST_WR_REQ : ST_RD_REQ;
            end
         end
         ST_WR_REQ: begin
            o_w_awvalid = !r_awDone;
            o_w_wvalid  = !r_wDone;
            if ((r_awDone || i_w_awready) && (r_wDone || i_w_wready)) begin
               w_stateNext = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            o_w_bready = 1'b1;
            if (i_w_bvalid) begin
               w_stateNext = ST_RSP;
            end
         end
         ST_RD_REQ: begin
            o_w_arvalid = 1'b1;
            if (i_w_arready) begin
               w_stateNext = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            o_w_rready = 1'b1;
            if (i_w_rvalid) begin
               w_stateNext = ST_RSP;
            end
         end
         ST_RSP: begin
            o_w_rsp_valid = 1'b1;
            if (i_w_rsp_ready) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // AW and W may complete in either order; each flag remembers its own handshake.
   always_ff @(posedge i_w_aclk) begin
      if (i_w_areset) begin
         r_awDone <= 1'b0;
         r_wDone  <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_resp   <= RESP_OKAY;
         r_rdata  <= '0;
      end else begin
         if (w_cmdHs) begin
            r_we     <= i_w_cmd_we;
            r_addr   <= i_w_cmd_addr;
            r_wdata  <= i_w_cmd_wdata;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
         end
         if (w_awHs) begin
            r_awDone <= 1'b1;
         end
         if (w_wHs) begin
            r_wDone <= 1'b1;
         end
         if (w_bHs) begin
            r_resp  <= i_w_bresp;
            r_rdata <= '0;
         end
         if (w_rHs) begin
            r_resp  <= i_w_rresp;
            r_rdata <= i_w_rdata;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI4-Lite slave with per-channel delays and a
// queue of expected responses filled when each command is issued.
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic          we;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
   } expRsp_t;

   logic aclk = 1'b0;
   logic areset;
   logic cmdValid, cmdReady, cmdWe;
   logic [AW-1:0] cmdAddr;
   logic [DW-1:0] cmdWdata;
   logic rspValid, rspReady, rspWe;
   logic [1:0] rspResp;
   logic [DW-1:0] rspRdata;
   logic awValid, awReady, wValid, wReady, bValid, bReady, arValid, arReady, rValid, rReady;
   logic [AW-1:0] awAddr, arAddr;
   logic [DW-1:0] wData, rData;
   logic [1:0] bResp, rResp;

   int checks = 0;
   int errors = 0;
   expRsp_t expQ[$];

   // Slave configuration and bookkeeping
   int awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
   logic [1:0] bRespVal = 2'b00;
   logic rOverride = 1'b0;
   logic [1:0] rRespOvr = 2'b00;
   logic [DW-1:0] rDataOvr = '0;
   logic [DW-1:0] mem [logic [AW-1:0]];
   int awCnt = 0, wCnt = 0, bCnt = 0, arCnt = 0, rCnt = 0;
   logic awGot = 0, wGot = 0, arGot = 0, bPend = 0, rPend = 0;
   logic sAwHs, sWHs, sBHs, sArHs, sRHs;
   logic [AW-1:0] slvAwAddr = '0, slvArAddr = '0, rAddrPend = '0;
   logic [DW-1:0] slvWData = '0;
   int bHsCount = 0;

   // Valid-high cycle counters and W payload stability tracking
   int awHighCnt = 0, wHighCnt = 0;
   logic wdataUnstable = 0, prevWvalid = 0;
   logic [DW-1:0] prevWdata = '0;

   always #5 aclk = ~aclk;

   axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_w_aclk(aclk), .i_w_areset(areset),
      .i_w_cmd_valid(cmdValid), .o_w_cmd_ready(cmdReady), .i_w_cmd_we(cmdWe),
      .i_w_cmd_addr(cmdAddr), .i_w_cmd_wdata(cmdWdata),
      .o_w_rsp_valid(rspValid), .i_w_rsp_ready(rspReady), .o_w_rsp_we(rspWe),
      .o_w_rsp_resp(rspResp), .o_w_rsp_rdata(rspRdata),
      .o_w_awvalid(awValid), .i_w_awready(awReady), .o_w_awaddr(awAddr),
      .o_w_wvalid(wValid), .i_w_wready(wReady), .o_w_wdata(wData),
      .i_w_bvalid(bValid), .o_w_bready(bReady), .i_w_bresp(bResp),
      .o_w_arvalid(arValid), .i_w_arready(arReady), .o_w_araddr(arAddr),
      .i_w_rvalid(rValid), .o_w_rready(rReady), .i_w_rresp(rResp), .i_w_rdata(rData)
   );

   // Slave: handshakes are taken from pre-edge values, responses are driven 1 time unit later.
   always @(posedge aclk) begin
      sAwHs = awValid && awReady;
      sWHs  = wValid && wReady;
      sBHs  = bValid && bReady;
      sArHs = arValid && arReady;
      sRHs  = rValid && rReady;
      if (sAwHs) begin slvAwAddr = awAddr; awGot = 1'b1; end
      if (sWHs) begin slvWData = wData; wGot = 1'b1; end
      if (sBHs) bHsCount++;
      if (sArHs) begin slvArAddr = arAddr; arGot = 1'b1; end
      #1;
      if (areset) begin
         awReady = 0; wReady = 0; arReady = 0; bValid = 0; rValid = 0;
         awGot = 0; wGot = 0; arGot = 0; bPend = 0; rPend = 0;
         awCnt = 0; wCnt = 0; arCnt = 0; bCnt = 0; rCnt = 0;
      end else begin
         if (sAwHs) begin awReady = 0; awCnt = 0; end
         else if (awValid && !awReady) begin if (awCnt >= awDelay) awReady = 1; else awCnt++; end
         if (sWHs) begin wReady = 0; wCnt = 0; end
         else if (wValid && !wReady) begin if (wCnt >= wDelay) wReady = 1; else wCnt++; end
         if (sArHs) begin arReady = 0; arCnt = 0; end
         else if (arValid && !arReady) begin if (arCnt >= arDelay) arReady = 1; else arCnt++; end
         if (awGot && wGot) begin
            mem[slvAwAddr] = slvWData;
            awGot = 0; wGot = 0; bPend = 1; bCnt = 0;
         end
         if (sBHs) bValid = 0;
         else if (bPend && !bValid) begin
            if (bCnt >= bDelay) begin bValid = 1; bResp = bRespVal; bPend = 0; end
            else bCnt++;
         end
         if (arGot) begin rPend = 1; rCnt = 0; arGot = 0; rAddrPend = slvArAddr; end
         if (sRHs) rValid = 0;
         else if (rPend && !rValid) begin
            if (rCnt >= rDelay) begin
               rValid = 1; rPend = 0;
               if (rOverride) begin rResp = rRespOvr; rData = rDataOvr; end
               else begin rResp = RESP_OKAY; rData = mem.exists(rAddrPend) ? mem[rAddrPend] : '0; end
            end else rCnt++;
         end
      end
   end

   always @(negedge aclk) begin
      if (awValid) awHighCnt++;
      if (wValid) begin
         wHighCnt++;
         if (prevWvalid && (wData !== prevWdata)) wdataUnstable = 1'b1;
      end
      prevWvalid = wValid;
      prevWdata  = wData;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   task automatic issueCommand(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [1:0] expResp, input logic [DW-1:0] expRdata, output logic timedOut);
      expRsp_t e;
      int waitCnt;
      e.we = we; e.resp = expResp; e.rdata = expRdata;
      expQ.push_back(e);
      timedOut = 0;
      waitCnt = 0;
      @(negedge aclk);
      cmdValid = 1; cmdWe = we; cmdAddr = addr; cmdWdata = wdata;
      while (!cmdReady && waitCnt < 300) begin @(negedge aclk); waitCnt++; end
      if (!cmdReady) timedOut = 1;
      else @(negedge aclk);
      cmdValid = 0;
   endtask

   task automatic waitResponse(input int readyDelay, output int lat, output logic oWe, output logic [1:0] oResp,
                               output logic [DW-1:0] oRdata, output logic stable, output logic busyReady,
                               output logic readyAfter, output logic timedOut);
      lat = 1; busyReady = 0; timedOut = 0; stable = 1; readyAfter = 0;
      oWe = 0; oResp = 0; oRdata = 0;
      while (!rspValid) begin
         if (cmdReady) busyReady = 1;
         if (lat > 300) begin timedOut = 1; return; end
         @(negedge aclk);
         lat++;
      end
      oWe = rspWe; oResp = rspResp; oRdata = rspRdata;
      if (cmdReady) busyReady = 1;
      repeat (readyDelay) begin
         @(negedge aclk);
         if (!rspValid || rspWe !== oWe || rspResp !== oResp || rspRdata !== oRdata) stable = 0;
         if (cmdReady) busyReady = 1;
      end
      rspReady = 1;
      @(negedge aclk);
      rspReady = 0;
      readyAfter = cmdReady && !rspValid;
   endtask

   task automatic popExpected(output expRsp_t e);
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_empty actual=0 entries expected>=1");
         e.we = 1'bx; e.resp = 2'bxx; e.rdata = 'x;
      end else e = expQ.pop_front();
   endtask

   task automatic test_reset();
      areset = 1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      areset = 0;
      checks++; if (cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready actual=%b expected=1", cmdReady); end
      checks++; if ({awValid, wValid, arValid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_valids actual=%b expected=000", {awValid, wValid, arValid}); end
      checks++; if ({bReady, rReady, rspValid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_readies actual=%b expected=000", {bReady, rReady, rspValid}); end
      checks++; if ({rspResp, rspRdata, awAddr} !== '0) begin errors++; $display("[TB] FAIL reset_regs resp=%b rdata=%h addr=%h expected all 0", rspResp, rspRdata, awAddr); end
   endtask

   task automatic test_write_basic();
      int lat; logic we, st, br, ra, to; logic [1:0] rs; logic [DW-1:0] rd; expRsp_t e;
      issueCommand(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, RESP_OKAY, '0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL wr_cmd_timeout actual=%b expected=0", to); end
      waitResponse(0, lat, we, rs, rd, st, br, ra, to);
      popExpected(e);
      checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL wr_rsp_timeout actual=%b expected=0", to); end
      checks++; if (slvAwAddr !== 32'h10) begin errors++; $display("[TB] FAIL wr_awaddr actual=%h expected=00000010", slvAwAddr); end
      checks++; if (slvWData !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_wdata actual=%h expected=deadbeef", slvWData); end
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL wr_latency actual=%0d expected=3", lat); end
      checks++; if ({we, rs, rd} !== {e.we, e.resp, e.rdata}) begin errors++; $display("[TB] FAIL wr_rsp actual=%b/%b/%h expected=%b/%b/%h", we, rs, rd, e.we, e.resp, e.rdata); end
   endtask

   task automatic test_read_basic();
      int lat; logic we, st, br, ra, to; logic [1:0] rs; logic [DW-1:0] rd; expRsp_t e;
      issueCommand(1'b0, 32'h0000_0010, 32'h0, RESP_OKAY, 32'hDEAD_BEEF, to);
      waitResponse(0, lat, we, rs, rd, st, br, ra, to);
      popExpected(e);
      checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL rd_timeout actual=%b expected=0", to); end
      checks++; if (slvArAddr !== 32'h10) begin errors++; $display("[TB] FAIL rd_araddr actual=%h expected=00000010", slvArAddr); end
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL rd_latency actual=%0d expected=3", lat); end
      checks++; if ({we, rs, rd} !== {e.we, e.resp, e.rdata}) begin errors++; $display("[TB] FAIL rd_rsp actual=%b/%b/%h expected=%b/%b/%h", we, rs, rd, e.we, e.resp, e.rdata); end
   endtask

   task automatic test_write_wready_delay();
      int lat, bBefore; logic we, st, br, ra, to; logic [1:0] rs; logic [DW-1:0] rd; expRsp_t e;
      wDelay = 3;
      awHighCnt = 0; wHighCnt = 0; wdataUnstable = 0; bBefore = bHsCount;
      issueCommand(1'b1, 32'h0000_0020, 32'h0BAD_CAFE, RESP_OKAY, '0, to);
      waitResponse(0, lat, we, rs, rd, st, br, ra, to);
      popExpected(e);
      wDelay = 0;
      checks++; if (awHighCnt !== 1) begin errors++; $display("[TB] FAIL wdly_aw_cycles actual=%0d expected=1", awHighCnt); end
      checks++; if (wHighCnt !== 4) begin errors++; $display("[TB] FAIL wdly_w_cycles actual=%0d expected=4", wHighCnt); end
      checks++; if (wdataUnstable !== 1'b0) begin errors++; $display("[TB] FAIL wdly_wdata_stable actual=%b expected=0", wdataUnstable); end
      checks++; if (bHsCount - bBefore !== 1) begin errors++; $display("[TB] FAIL wdly_b_count actual=%0d expected=1", bHsCount - bBefore); end
      checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL wdly_latency actual=%0d expected=6", lat); end
      checks++; if ({we, rs, rd} !== {e.we, e.resp, e.rdata}) begin errors++; $display("[TB] FAIL wdly_rsp actual=%b/%b/%h expected=%b/%b/%h", we, rs, rd, e.we, e.resp, e.rdata); end
   endtask

   task automatic test_read_slow_rsp();
      int lat; logic we, st, br, ra, to; logic [1:0] rs; logic [DW-1:0] rd; expRsp_t e;
      rDelay = 5;
      issueCommand(1'b0, 32'h0000_0010, 32'h0, RESP_OKAY, 32'hDEAD_BEEF, to);
      waitResponse(2, lat, we, rs, rd, st, br, ra, to);
      popExpected(e);
      rDelay = 0;
      checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL slow_latency actual=%0d expected=8", lat); end
      checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL slow_rsp_stable actual=%b expected=1", st); end
      checks++; if (br !== 1'b0) begin errors++; $display("[TB] FAIL slow_cmd_ready_busy actual=%b expected=0", br); end
      checks++; if (ra !== 1'b1) begin errors++; $display("[TB] FAIL slow_ready_after actual=%b expected=1", ra); end
      checks++; if ({we, rs, rd} !== {e.we, e.resp, e.rdata}) begin errors++; $display("[TB] FAIL slow_rsp actual=%b/%b/%h expected=%b/%b/%h", we, rs, rd, e.we, e.resp, e.rdata); end
   endtask

   task automatic test_read_slverr();
      int lat; logic we, st, br, ra, to; logic [1:0] rs; logic [DW-1:0] rd; expRsp_t e;
      rOverride = 1; rRespOvr = RESP_SLVERR; rDataOvr = 32'h0000_1234;
      issueCommand(1'b0, 32'h0000_0030, 32'h0, RESP_SLVERR, 32'h0000_1234, to);
      waitResponse(0, lat, we, rs, rd, st, br, ra, to);
      popExpected(e);
      rOverride = 0;
      checks++; if (rs !== e.resp) begin errors++; $display("[TB] FAIL slverr_resp actual=%b expected=%b", rs, e.resp); end
      checks++; if ({we, rd} !== {e.we, e.rdata}) begin errors++; $display("[TB] FAIL slverr_data actual=%b/%h expected=%b/%h", we, rd, e.we, e.rdata); end
   endtask

   task automatic test_write_decerr();
      int lat; logic we, st, br, ra, to; logic [1:0] rs; logic [DW-1:0] rd; expRsp_t e;
      bRespVal = RESP_DECERR;
      issueCommand(1'b1, 32'h0000_0050, 32'h5555_AAAA, RESP_DECERR, '0, to);
      waitResponse(0, lat, we, rs, rd, st, br, ra, to);
      popExpected(e);
      bRespVal = RESP_OKAY;
      checks++; if ({we, rs, rd} !== {e.we, e.resp, e.rdata}) begin errors++; $display("[TB] FAIL decerr_rsp actual=%b/%b/%h expected=%b/%b/%h", we, rs, rd, e.we, e.resp, e.rdata); end
   endtask

   task automatic test_reset_mid_write();
      int waitCnt; logic to, sawRsp;
      bDelay = 30;
      issueCommand(1'b1, 32'h0000_0070, 32'hBEEF_0001, RESP_OKAY, '0, to);
      waitCnt = 0;
      while (!bReady && waitCnt < 50) begin @(negedge aclk); waitCnt++; end
      checks++; if (bReady !== 1'b1) begin errors++; $display("[TB] FAIL midrst_reach_wr_resp actual=%b expected=1", bReady); end
      areset = 1;
      @(negedge aclk);
      areset = 0;
      expQ.delete();
      checks++; if ({awValid, wValid, arValid, bReady, rReady, rspValid} !== 6'b0) begin errors++; $display("[TB] FAIL midrst_outputs actual=%b expected=000000", {awValid, wValid, arValid, bReady, rReady, rspValid}); end
      checks++; if (cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL midrst_cmd_ready actual=%b expected=1", cmdReady); end
      sawRsp = 0;
      repeat (40) begin @(negedge aclk); if (rspValid) sawRsp = 1; end
      checks++; if (sawRsp !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_rsp actual=%b expected=0", sawRsp); end
      bDelay = 0;
   endtask

   task automatic test_back_to_back();
      int lat; logic we, st, br, ra, to; logic [1:0] rs; logic [DW-1:0] rd; expRsp_t e, eB;
      issueCommand(1'b1, 32'h0000_0060, 32'hCAFE_F00D, RESP_OKAY, '0, to);
      eB.we = 0; eB.resp = RESP_OKAY; eB.rdata = 32'hCAFE_F00D;
      expQ.push_back(eB);
      cmdValid = 1; cmdWe = 0; cmdAddr = 32'h0000_0060; cmdWdata = '0;
      waitResponse(0, lat, we, rs, rd, st, br, ra, to);
      popExpected(e);
      checks++; if ({we, rs, rd} !== {e.we, e.resp, e.rdata}) begin errors++; $display("[TB] FAIL b2b_first_rsp actual=%b/%b/%h expected=%b/%b/%h", we, rs, rd, e.we, e.resp, e.rdata); end
      checks++; if (ra !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after actual=%b expected=1", ra); end
      @(negedge aclk);
      cmdValid = 0;
      waitResponse(0, lat, we, rs, rd, st, br, ra, to);
      popExpected(e);
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL b2b_second_latency actual=%0d expected=3", lat); end
      checks++; if ({we, rs, rd} !== {e.we, e.resp, e.rdata}) begin errors++; $display("[TB] FAIL b2b_second_rsp actual=%b/%b/%h expected=%b/%b/%h", we, rs, rd, e.we, e.resp, e.rdata); end
   endtask

   initial begin
      areset = 1; cmdValid = 0; cmdWe = 0; cmdAddr = '0; cmdWdata = '0; rspReady = 0;
      awReady = 0; wReady = 0; arReady = 0; bValid = 0; rValid = 0;
      bResp = '0; rResp = '0; rData = '0;
      test_reset();
      test_write_basic();
      test_read_basic();
      test_write_wready_delay();
      test_read_slow_rsp();
      test_read_slverr();
      test_write_decerr();
      test_reset_mid_write();
      test_back_to_back();
      checks++; if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_leftover actual=%0d expected=0", expQ.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
